spec_add_recover: RTL
=====================

SPEC_ADD_RECOVER -- requirements
Module: spec_add_recover

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width; must be a multiple of BLK.
REQ-002 SHALL have parameter BLK, default 4: speculation block width; must be at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operands on a and b are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: addends.
REQ-008 SHALL have port out_valid, output, 1 bit: sum, cout and err are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port sum, output, WIDTH bits: result.
REQ-011 SHALL have port cout, output, 1 bit: carry out of the MSB block.
REQ-012 SHALL have port err, output, 1 bit: a speculation miss occurred on this result.

Function
REQ-013 SHALL complete an input transfer when in_valid and in_ready are both high on a clock edge, and an output transfer when out_valid and out_ready are both high on a clock edge.
REQ-014 SHALL split each operand pair into WIDTH/BLK blocks; block 0 carry-in = 0; block k>0 predicted carry-in = a[k*BLK-1] & b[k*BLK-1].
REQ-015 SHALL register the speculative sum on accept; a miss for block k SHALL be flagged when the exact carry out of block k-1 differs from the predicted carry-in of block k.
REQ-016 SHALL use FSM states S_IDLE (nothing held), S_OUT (result held, out_valid=1) and S_FIX (correction cycle, out_valid=0).
REQ-017 SHALL transition on accept with no miss to S_OUT: speculative result, err=0, latency 1 cycle.
REQ-018 SHALL transition on accept with any miss to S_FIX; the next edge SHALL load the exact sum and cout, set err=1 and go to S_OUT: latency 2 cycles.
REQ-019 SHALL drive in_ready = (state==S_IDLE) | (state==S_OUT & out_ready); in S_FIX in_ready SHALL be 0.
REQ-020 SHALL handle simultaneous output transfer and input transfer in S_OUT by replacing the held result per REQ-017/018, giving full throughput when no miss occurs.
REQ-021 SHALL go from S_OUT to S_IDLE on an output transfer with no new input; sum, cout and err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 SHALL wrap sum modulo 2^WIDTH; cout SHALL equal bit WIDTH of the exact a+b whenever err=1 or no miss occurred.

Reset
REQ-023 SHALL on rst force state S_IDLE, out_valid=0, sum=0, cout=0, err=0, and in_ready=1 after release; an assertion mid-S_FIX SHALL discard the pending operation with no output.

Configuration
REQ-024 SHALL, with SPEC_ADD_FIX_EN defined, behave as REQ-018.
REQ-025 SHALL, without SPEC_ADD_FIX_EN, omit S_FIX and the exact-sum path: every accept goes to S_OUT at latency 1 with the speculative sum and err set when a miss occurred (approximate mode).

Structure
REQ-026 SHALL place the state enum (S_IDLE, S_OUT, S_FIX) and the WIDTH/BLK defaults in package spec_add_pkg.
REQ-027 SHALL use one sub-module, spec_blk: a BLK-bit adder taking a predicted carry-in and giving a block sum plus the exact block generate/propagate carry-out; instantiate it WIDTH/BLK times.

Verification (WIDTH=8, BLK=4, SPEC_ADD_FIX_EN unless noted)
REQ-028 SHALL cover: a=0x12, b=0x34, out_ready=1 -> sum=0x46, cout=0, err=0, out_valid one cycle after accept.
REQ-029 SHALL cover: a=0x0F, b=0x01 -> in_ready=0 for one cycle; sum=0x10, err=1, out_valid two cycles after accept.
REQ-030 SHALL cover: a=0x0F, b=0x01 without SPEC_ADD_FIX_EN -> sum=0x00, err=1, latency 1.
REQ-031 SHALL cover: a=0xF8, b=0x18 -> predicted carry hit; sum=0x10, cout=1, err=0.
REQ-032 SHALL cover: out_ready=0 for 3 cycles after a result -> sum held, in_ready=0; on release a back-to-back accept occurs in the same cycle.
REQ-033 SHALL cover: rst asserted during S_FIX -> out_valid=0 and sum=0 immediately; no stale result after release.

Source files
------------

// File: rtl/spec_add_pkg.sv
// spec_add_pkg -- shared definitions for the speculative block adder.
//
// Contents:
//   DEF_WIDTH : default operand/sum width
//   DEF_BLK   : default speculation block width
//   state_t   : controller states (S_IDLE, S_OUT, S_FIX)
package spec_add_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BLK   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // nothing held
        S_OUT  = 2'd1,  // result held, out_valid high
        S_FIX  = 2'd2   // correction cycle after a speculation miss
    } state_t;

endpackage

// File: rtl/spec_blk.sv
// spec_blk -- one BLK-bit slice of the speculative adder.
//
// Adds a_i + b_i + cin_i where cin_i is the predicted carry-in. Also reports
// the slice's generate/propagate terms so the parent can form the exact
// carry chain independently of the prediction.
//
// Ports:
//   a_i, b_i  : BLK-bit addend slices
//   cin_i     : predicted carry into this slice
//   sum_o     : BLK-bit slice sum using the predicted carry
//   g_o       : slice generates a carry on its own
//   p_o       : slice propagates an incoming carry
module spec_blk #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a_i,
    input  logic [BLK-1:0] b_i,
    input  logic           cin_i,
    output logic [BLK-1:0] sum_o,
    output logic           g_o,
    output logic           p_o
);

    logic [BLK:0] raw;

    assign raw   = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o = raw[BLK-1:0] + {{(BLK-1){1'b0}}, cin_i};
    assign g_o   = raw[BLK];
    // All-ones half sum: an incoming carry ripples straight through.
    assign p_o   = &(a_i ^ b_i);

endmodule

// File: rtl/spec_add_recover.sv
// spec_add_recover -- speculative carry-select adder with miss recovery.
//
// Each operand pair is split into WIDTH/BLK slices. Slice k>0 guesses its
// carry-in from the MSB pair of slice k-1 (a&b). The guess is checked
// against the exact carry chain built from slice generate/propagate terms.
//
// Build option SPEC_ADD_FIX_EN:
//   defined   : a miss costs one extra cycle (S_FIX) that loads the exact
//               sum; err=1 marks the corrected result.
//   undefined : approximate mode, every result is the speculative sum at
//               latency 1, err=1 flags that it may be wrong.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; a held result (out_valid=1) stays stable until taken.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : a/b valid       in_ready  : operands can be taken
//   a, b       : WIDTH-bit addends
//   out_valid  : sum/cout/err valid
//   out_ready  : consumer takes the result
//   sum, cout  : result and carry out of the MSB slice
//   err        : a speculation miss occurred on this result
module spec_add_recover
    import spec_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err
);

    localparam int NBLK = WIDTH / BLK;

    state_t           state_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             err_q;
`ifdef SPEC_ADD_FIX_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
`endif

    logic [WIDTH-1:0] spec_sum;
    logic [NBLK-1:0]  pred_c;
    logic [NBLK-1:0]  blk_g;
    logic [NBLK-1:0]  blk_p;
    logic [NBLK:0]    exact_c;
    logic             miss;
    logic             accept;

    genvar k;
    generate
        for (k = 0; k < NBLK; k++) begin : g_blk
            if (k == 0) begin : g_first
                assign pred_c[k] = 1'b0;
            end else begin : g_rest
                assign pred_c[k] = a[k*BLK-1] & b[k*BLK-1];
            end

            spec_blk #(.BLK(BLK)) u_blk (
                .a_i   (a[k*BLK +: BLK]),
                .b_i   (b[k*BLK +: BLK]),
                .cin_i (pred_c[k]),
                .sum_o (spec_sum[k*BLK +: BLK]),
                .g_o   (blk_g[k]),
                .p_o   (blk_p[k])
            );
        end
    endgenerate

    // Exact carry chain; exact_c[NBLK] is the true carry out in every case,
    // so cout never depends on whether the prediction held.
    always_comb begin
        exact_c    = '0;
        miss       = 1'b0;
        exact_c[0] = 1'b0;
        for (int i = 0; i < NBLK; i++) begin
            exact_c[i+1] = blk_g[i] | (blk_p[i] & exact_c[i]);
            if (i > 0 && exact_c[i] != pred_c[i]) begin
                miss = 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_OUT) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_OUT);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SPEC_ADD_FIX_EN
            a_q     <= '0;
            b_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_OUT: begin
                    if (accept) begin
                        cout_q <= exact_c[NBLK];
`ifdef SPEC_ADD_FIX_EN
                        if (miss) begin
                            // Keep the operands; the exact sum is formed next cycle.
                            a_q     <= a;
                            b_q     <= b;
                            state_q <= S_FIX;
                        end else begin
                            sum_q   <= spec_sum;
                            err_q   <= 1'b0;
                            state_q <= S_OUT;
                        end
`else
                        sum_q   <= spec_sum;
                        err_q   <= miss;
                        state_q <= S_OUT;
`endif
                    end else if (state_q == S_OUT && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
`ifdef SPEC_ADD_FIX_EN
                S_FIX: begin
                    sum_q   <= a_q + b_q;
                    err_q   <= 1'b1;
                    state_q <= S_OUT;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
